session_timeout_ctrl: RTL and testbench

SESSION_TIMEOUT_CTRL -- requirements
Module: session_timeout_ctrl

---
 rtl/atm_pkg.sv | 23 ++
 rtl/session_timeout_ctrl.sv | 131 +++++++++++++
 tb/tb_session_timeout_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// ============================================================================
// Module      : atm_pkg
// Description : Shared ATM session types and defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_REARM       = 3'd1,
    ST_RUN         = 3'd2,
    ST_HOLD        = 3'd3,
    ST_EXPIRE      = 3'd4,
    ST_WAIT_REMOVE = 3'd5
  } sess_state_e;

  localparam int MAX_WARN_DEFAULT = 1;

endpackage

`default_nettype wire

// File: rtl/session_timeout_ctrl.sv
// ============================================================================
// Module      : session_timeout_ctrl
// Description : Card-session supervisor driving an external inactivity timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module session_timeout_ctrl
  import atm_pkg::*;
#(
  parameter int MAX_WARN = MAX_WARN_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic card_in,
  input  logic activity,
  input  logic busy,
  input  logic timeout,
  output logic timer_start,
  output logic timer_restart,
  output logic session_active,
  output logic warn,
  output logic expire
);

  localparam logic [1:0] C_MAX_WARN = 2'(MAX_WARN);

  sess_state_e state_q, state_d;
  logic [1:0]  warn_cnt_q, warn_cnt_d;
  logic        warn_q, warn_d;
  logic        timer_start_q, timer_start_d;
  logic        timer_restart_q, timer_restart_d;
  logic        session_active_q, session_active_d;
  logic        expire_q, expire_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      warn_cnt_q       <= 2'd0;
      warn_q           <= 1'b0;
      timer_start_q    <= 1'b0;
      timer_restart_q  <= 1'b0;
      session_active_q <= 1'b0;
      expire_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      warn_cnt_q       <= warn_cnt_d;
      warn_q           <= warn_d;
      timer_start_q    <= timer_start_d;
      timer_restart_q  <= timer_restart_d;
      session_active_q <= session_active_d;
      expire_q         <= expire_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    warn_cnt_d = warn_cnt_q;
    warn_d     = warn_q;

    // Card removal overrides everything and never produces an expire pulse.
    if (state_q != ST_IDLE && !card_in) begin
      state_d    = ST_IDLE;
      warn_cnt_d = 2'd0;
      warn_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (card_in) begin
            state_d    = ST_REARM;
            warn_cnt_d = 2'd0;
            warn_d     = 1'b0;
          end
        end
        ST_REARM: begin
          state_d = ST_RUN;
          if (activity) begin
            warn_cnt_d = 2'd0;
            warn_d     = 1'b0;
          end
        end
        ST_RUN: begin
          if (activity) begin
            state_d    = ST_REARM;
            warn_cnt_d = 2'd0;
            warn_d     = 1'b0;
          end else if (timeout) begin
            if (warn_cnt_q < C_MAX_WARN) begin
              state_d    = ST_REARM;
              warn_cnt_d = warn_cnt_q + 2'd1;
              warn_d     = 1'b1;
            end else begin
              state_d = ST_EXPIRE;
            end
          end else if (busy) begin
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (activity) begin
            state_d    = ST_REARM;
            warn_cnt_d = 2'd0;
            warn_d     = 1'b0;
          end else if (!busy) begin
            state_d = ST_RUN;
          end
        end
        ST_EXPIRE:      state_d = ST_WAIT_REMOVE;
        ST_WAIT_REMOVE: state_d = ST_WAIT_REMOVE;
        default:        state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    timer_start_d    = (state_d == ST_RUN) || (state_d == ST_HOLD);
    timer_restart_d  = (state_d == ST_HOLD);
    session_active_d = (state_d != ST_IDLE);
    expire_d         = (state_d == ST_EXPIRE);
  end

  assign timer_start    = timer_start_q;
  assign timer_restart  = timer_restart_q;
  assign session_active = session_active_q;
  assign warn           = warn_q;
  assign expire         = expire_q;

endmodule

`default_nettype wire

// File: tb/tb_session_timeout_ctrl.sv
// ============================================================================
// Module      : tb_session_timeout_ctrl
// Description : Self-checking bench with an 11-cycle timer and session model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_session_timeout_ctrl;

  localparam int MW = 1;
  localparam int TIMER_LEN = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic card_in = 1'b0;
  logic activity = 1'b0;
  logic busy = 1'b0;
  logic timeout;
  logic timer_start, timer_restart, session_active, warn, expire;

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  session_timeout_ctrl #(.MAX_WARN(MW)) dut (
    .clk            (clk),
    .rst            (rst),
    .card_in        (card_in),
    .activity       (activity),
    .busy           (busy),
    .timeout        (timeout),
    .timer_start    (timer_start),
    .timer_restart  (timer_restart),
    .session_active (session_active),
    .warn           (warn),
    .expire         (expire)
  );

  // Environment timer: cleared while start is low, frozen by restart.
  int tcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) tcnt <= 0;
    else if (!timer_start) tcnt <= 0;
    else if (!timer_restart && tcnt < TIMER_LEN) tcnt <= tcnt + 1;
  end
  assign timeout = (tcnt == TIMER_LEN);

  // Behavioural session model built from independent flags.
  bit m_sess, m_rearm, m_hold, m_pulse, m_waiting, m_warn;
  int m_warns;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_sess = 0; m_rearm = 0; m_hold = 0; m_pulse = 0; m_waiting = 0;
      m_warn = 0; m_warns = 0;
    end else if (!m_sess) begin
      if (card_in) begin
        m_sess = 1; m_rearm = 1; m_warns = 0; m_warn = 0;
      end
    end else if (!card_in) begin
      m_sess = 0; m_rearm = 0; m_hold = 0; m_pulse = 0; m_waiting = 0;
      m_warn = 0; m_warns = 0;
    end else if (m_waiting) begin
      m_waiting = 1;
    end else if (m_pulse) begin
      m_pulse = 0; m_waiting = 1;
    end else if (m_rearm) begin
      m_rearm = 0;
      if (activity) begin m_warns = 0; m_warn = 0; end
    end else if (m_hold) begin
      if (activity) begin
        m_hold = 0; m_rearm = 1; m_warns = 0; m_warn = 0;
      end else if (!busy) m_hold = 0;
    end else begin
      if (activity) begin
        m_rearm = 1; m_warns = 0; m_warn = 0;
      end else if (timeout) begin
        if (m_warns < MW) begin
          m_warns++; m_warn = 1; m_rearm = 1;
        end else m_pulse = 1;
      end else if (busy) m_hold = 1;
    end
  end

  function automatic logic [4:0] model_out();
    logic ts;
    ts = m_sess && !m_rearm && !m_pulse && !m_waiting;
    return {ts, m_hold, m_sess, m_warn, m_pulse};
  endfunction

  wire [4:0] dut_out = {timer_start, timer_restart, session_active, warn, expire};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst) chk("model_cmp {start,restart,active,warn,expire}", 32'(dut_out), 32'(model_out()));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_session();
    card_in = 1'b1;
    step();
    step();
  endtask

  initial begin
    int lat;
    bit hold_ok;

    // Reset state
    #2;
    chk("reset_outputs", 32'(dut_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;

    // Session start: timer_start low one cycle, then high
    card_in = 1'b1;
    step();
    chk("start_active", 32'(session_active), 32'd1);
    chk("start_timer_low", 32'(timer_start), 32'd0);
    step();
    chk("start_timer_high", 32'(timer_start), 32'd1);

    // Unattended: first timeout warns, second expires
    lat = 0;
    while (!warn && lat < 40) begin step(); lat++; end
    chk("warn_latency", 32'(lat), 32'd12);
    chk("warn_no_expire", 32'(expire), 32'd0);
    lat = 0;
    while (!expire && lat < 40) begin step(); lat++; end
    chk("expire_latency", 32'(lat), 32'd13);
    step();
    chk("expire_one_cycle", 32'(expire), 32'd0);
    chk("wait_remove_active", 32'(session_active), 32'd1);
    card_in = 1'b0;
    step();
    chk("removed_idle", 32'({session_active, warn}), 32'd0);

    // Activity 8 cycles into RUN restarts the timer
    start_session();
    repeat (7) step();
    activity = 1'b1;
    step();
    activity = 1'b0;
    repeat (5) step();
    chk("activity_no_warn", 32'(warn), 32'd0);

    // Busy hold for 20 cycles
    busy = 1'b1;
    step();
    hold_ok = 1'b1;
    repeat (20) begin
      if (!timer_restart || warn || expire) hold_ok = 1'b0;
      step();
    end
    chk("hold_restart_steady", 32'(hold_ok), 32'd1);
    busy = 1'b0;
    step();
    chk("hold_release", 32'({timer_start, timer_restart}), 32'b10);
    card_in = 1'b0;
    step();

    // Card removed together with timeout
    start_session();
    lat = 0;
    while (!timeout && lat < 40) begin step(); lat++; end
    chk("timeout_seen", 32'(timeout), 32'd1);
    card_in = 1'b0;
    step();
    chk("remove_on_timeout", 32'({session_active, warn, expire}), 32'd0);
    step();
    chk("remove_no_late_expire", 32'(expire), 32'd0);

    // Asynchronous reset while holding
    start_session();
    busy = 1'b1;
    step();
    step();
    chk("in_hold", 32'(timer_restart), 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("async_reset_outputs", 32'(dut_out), 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    busy = 1'b0;
    step();
    chk("post_reset_rearm", 32'({session_active, timer_start}), 32'b10);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      if (card_in) begin
        if ($urandom_range(0, 79) == 0) card_in = 1'b0;
      end else if ($urandom_range(0, 3) == 0) card_in = 1'b1;
      activity = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) busy = ~busy;
    end
    activity = 1'b0;
    busy = 1'b0;
    card_in = 1'b0;
    repeat (3) step();
    chk("final_idle", 32'(session_active), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
